// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
//   state_e      : controller state (IDLE, BUSY)
//   digit_e      : recoded Booth digit (ZERO, POS1, POS2, NEG1, NEG2)
//   booth_recode : maps a 3-bit multiplier group {b(i+1), b(i), b(i-1)} to a digit
package booth_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } digit_e;

  function automatic digit_e booth_recode(input logic [2:0] grp);
    digit_e d;
    case (grp)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Combinational radix-4 Booth recoder.
// Ports:
//   grp_i : 3-bit multiplier group {b(i+1), b(i), b(i-1)}
//   one_o : select 1*M
//   two_o : select 2*M
//   neg_o : negate the selected multiple
// one_o = two_o = 0 selects zero.
module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [2:0] grp_i,
  output logic       one_o,
  output logic       two_o,
  output logic       neg_o
);

  digit_e digit;

  assign digit = booth_recode(grp_i);

  always_comb begin
    one_o = 1'b0;
    two_o = 1'b0;
    neg_o = 1'b0;
    case (digit)
      POS1: one_o = 1'b1;
      POS2: two_o = 1'b1;
      NEG1: begin
        one_o = 1'b1;
        neg_o = 1'b1;
      end
      NEG2: begin
        two_o = 1'b1;
        neg_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/booth_multiplier_r4.sv
// Radix-4 Booth sequential multiplier, two multiplier bits retired per cycle.
// Optional feature macro: BOOTH_R4_UNSIGNED_EN (adds the uns port; uns=1 runs
// an extra iteration on a zero-extended multiplier for an unsigned product).
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request, accepted when ready=1
//   m, r  : multiplicand / multiplier, sampled on the accepting edge
//   uns   : unsigned mode (only with BOOTH_R4_UNSIGNED_EN)
//   ans   : 2*WIDTH product, held until the next completion
//   ready : idle, start will be accepted
//   done  : one-cycle pulse on the edge that loads ans
module booth_multiplier_r4
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   r,
`ifdef BOOTH_R4_UNSIGNED_EN
  input  logic               uns,
`endif
  output logic [2*WIDTH-1:0] ans,
  output logic               ready,
  output logic               done
);

  // Accumulator and multiplier are both WIDTH+2 wide so that +-2M of the
  // most-negative operand and the unsigned extension need no special case.
  // Product register layout: {acc[AW-1:0], mplr[AW-1:0], q_minus_1}.
  localparam int AW = WIDTH + 2;
  localparam int PW = 2 * AW + 1;
  localparam int CW = $clog2(WIDTH / 2 + 2);
  localparam logic [CW-1:0] LAST_S = CW'(WIDTH / 2 - 1);
  localparam logic [CW-1:0] LAST_U = CW'(WIDTH / 2);

  logic uns_in;
`ifdef BOOTH_R4_UNSIGNED_EN
  assign uns_in = uns;
`else
  assign uns_in = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [PW-1:0]      preg_q, preg_d;
  logic [AW-1:0]      mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               uns_q, uns_d;
  logic [2*WIDTH-1:0] ans_q, ans_d;
  logic               done_q, done_d;

  logic          sel_one, sel_two, sel_neg;
  logic [AW-1:0] mag, pp, acc_sum;
  logic [PW-1:0] shifted;

  booth_r4_recoder u_recoder (
    .grp_i (preg_q[2:0]),
    .one_o (sel_one),
    .two_o (sel_two),
    .neg_o (sel_neg)
  );

  always_comb begin
    mag = '0;
    if (sel_two)      mag = {mcand_q[AW-2:0], 1'b0};
    else if (sel_one) mag = mcand_q;
  end

  assign pp      = sel_neg ? (~mag + 1'b1) : mag;
  assign acc_sum = preg_q[PW-1:AW+1] + pp;
  // Arithmetic shift right by 2 of {acc_sum, mplr, q_minus_1}.
  assign shifted = {{2{acc_sum[AW-1]}}, acc_sum, preg_q[AW:2]};

  always_comb begin
    state_d = state_q;
    preg_d  = preg_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    uns_d   = uns_q;
    ans_d   = ans_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          uns_d   = uns_in;
          cnt_d   = '0;
          mcand_d = uns_in ? {2'b00, m} : {{2{m[WIDTH-1]}}, m};
          preg_d  = {{AW{1'b0}}, (uns_in ? {2'b00, r} : {{2{r[WIDTH-1]}}, r}), 1'b0};
        end
      end
      BUSY: begin
        preg_d = shifted;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == (uns_q ? LAST_U : LAST_S)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          // Signed runs stop two shifts early, leaving the multiplier's
          // extension bits at the bottom; unsigned runs consume them.
          ans_d   = uns_q ? shifted[2*WIDTH:1] : shifted[2*WIDTH+2:3];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      preg_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      uns_q   <= 1'b0;
      ans_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      preg_q  <= preg_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      uns_q   <= uns_d;
      ans_q   <= ans_d;
      done_q  <= done_d;
    end
  end

  assign ans   = ans_q;
  assign ready = (state_q == IDLE);
  assign done  = done_q;

endmodule

// File: doc/booth_multiplier_r4.md
# booth_multiplier_r4

Parametrised radix-4 Booth sequential multiplier, successor to the 8-bit radix-2 multiplier. It multiplies two WIDTH-bit two's-complement operands, retiring two multiplier bits per cycle. It produces a registered 2*WIDTH-bit product with a start/ready handshake and a one-cycle done pulse. It is correct for the most-negative operand without any post-correction, and optionally supports unsigned operands.

## Interface
- WIDTH, 8, operand width; even, >= 4
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only on an edge where ready=1
- m  input  WIDTH  multiplicand, sampled on the accepting edge
- r  input  WIDTH  multiplier, sampled on the accepting edge
- uns  input  1  unsigned mode, sampled with operands (present only with BOOTH_R4_UNSIGNED_EN)
- ans  output  2*WIDTH  product register, held until the next completion
- ready  output  1  idle, able to accept start
- done  output  1  one-cycle pulse, ans updated this cycle

## Operation
- States: IDLE and BUSY.
- IDLE -> BUSY when start=1 and ready=1.
- BUSY -> IDLE on the last iteration. That same edge loads ans, sets done=1 and sets ready=1.
- On acceptance:
  - multiplicand registered sign-extended to WIDTH+2 bits (zero-extended if uns=1)
  - accumulator cleared
  - multiplier registered with an appended 0 LSB
  - iteration counter cleared
- Each BUSY cycle:
  - the recoder maps the low 3 multiplier bits to a digit in {-2,-1,0,+1,+2}
  - the selected 0/±M/±2M (WIDTH+2 bits) is added to the upper accumulator
  - the whole product register is arithmetic-shifted right by 2
- Iteration count N = WIDTH/2 for signed operands.
- Iteration count N+1 for unsigned operands: the multiplier is zero-extended by 2 bits, and the extra iteration consumes the extension.
- ±2M is formed at WIDTH+2 bits, so m = -2^(WIDTH-1) needs no special case.
- Overflow of the WIDTH+2 partial sum is impossible by construction. Any such overflow is a design bug.
- ans = low 2*WIDTH bits of the final product. It is the exact signed (or unsigned) product.
- start while BUSY is ignored, and operand changes while BUSY have no effect.
- Reset values: ready=1, done=0, ans=0, state IDLE, counter 0.
- rst mid-operation aborts the operation:
  - the partial result is discarded
  - no done pulse
  - ans returns to 0

## Timing
- Edge E0: start sampled with ready=1. After E0: ready=0, done=0.
- Signed: ans valid and done=1 after edge E0+N; latency N cycles (4 for WIDTH=8).
- Unsigned: the same, after edge E0+N+1.
- ready=1 in the same cycle as done. A start in the done cycle is accepted, so back-to-back throughput is one result per N+1 cycles.
- done is high for exactly one cycle per completed operation.
- ready and done are registered, with no combinational path from inputs.

## Configuration
- BOOTH_R4_UNSIGNED_EN defined:
  - uns port exists
  - uns=1 selects zero-extension and N+1 iterations
  - uns=0 behaves exactly as the signed build
- Undefined:
  - no uns port
  - always signed
  - always N iterations

## Structure
- Shared package booth_pkg:
  - state enum (IDLE, BUSY)
  - recoded-digit typedef (ZERO, POS1, POS2, NEG1, NEG2)
  - recode function of a 3-bit group
- Sub-module booth_r4_recoder:
  - combinational
  - 3-bit group in; digit select and negate flag out
  - instantiated once.
- The accumulator/shift datapath and FSM live in the top module.

## Test plan
- WIDTH=8, m=7, r=-3 -> ans=0xFFEB (-21), done exactly 4 cycles after start, single pulse.
- m=-128, r=-128 -> 0x4000. m=-128, r=1 -> 0xFF80. m=127, r=127 -> 0x3F01.
- Unsigned build, uns=1, m=255, r=255 -> 0xFE01 after 5 cycles. uns=0 with the same inputs -> 0x0001 after 4 cycles.
- start pulsed again at cycle 2 of BUSY with different operands -> ignored; first result correct; ready stays 0 until done.
- rst=1 at cycle 2 of BUSY -> next cycle ready=1, ans=0, no done pulse. A new start then yields a correct product.
- start held high continuously with changing operands -> each done cycle re-accepts. Results match operands sampled on each accepting edge; random signed sweep versus reference product for WIDTH=8 and WIDTH=16.
